// File: rtl/lt24_hires_nios2_gen2_0_cpu_div_cell.sv
// lt24_hires_nios2_gen2_0_cpu_div_cell: iterative radix-2 restoring divider for div/divu
module lt24_hires_nios2_gen2_0_cpu_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] E_src1,
  input  logic [DATA_WIDTH-1:0] E_src2,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic                  div_kill,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] div_quotient,
  output logic [DATA_WIDTH-1:0] div_remainder
);
  localparam int W = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] src1, src2, rem, quo, dvs, mag1, mag2;
  logic [W:0] rem_sh, trial;
  logic [CW-1:0] cnt;
  logic sgn, q_neg, r_neg, s1, s2, accept, last, zero_div;
  assign accept = (state == IDLE || state == DONE) && div_start && !div_kill;
  assign s1 = sgn & src1[W-1];
  assign s2 = sgn & src2[W-1];
  assign mag1 = s1 ? -src1 : src1;
  assign mag2 = s2 ? -src2 : src2;
  assign zero_div = src2 == '0;
  assign rem_sh = {rem, quo[W-1]};
  assign trial = rem_sh - {1'b0, dvs};
  assign last = cnt == CW'(W - 1);
  assign div_busy = state == PREP || state == CALC || state == FIXUP;
  assign div_done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state logic; a kill aborts any busy state and suppresses a start when idle
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? PREP : IDLE;
      PREP:    state_nx = div_kill ? IDLE : zero_div ? DONE : CALC;
      CALC:    state_nx = div_kill ? IDLE : last ? FIXUP : CALC;
      FIXUP:   state_nx = div_kill ? IDLE : DONE;
      DONE:    state_nx = accept ? PREP : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // operand capture, magnitude shift-subtract loop and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1 <= '0;
      src2 <= '0;
      sgn <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      div_quotient <= '0;
      div_remainder <= '0;
    end else begin
      if (accept) begin
        src1 <= E_src1;
        src2 <= E_src2;
        sgn <= div_signed;
      end
      if (state == PREP) begin
        q_neg <= s1 ^ s2;
        r_neg <= s1;
        rem <= '0;
        quo <= mag1;
        dvs <= mag2;
        cnt <= '0;
        if (zero_div && !div_kill) begin
          div_quotient <= '1;
          div_remainder <= src1;
        end
      end
      if (state == CALC) begin
        rem <= trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        quo <= {quo[W-2:0], ~trial[W]};
        cnt <= cnt + 1'b1;
      end
      if (state == FIXUP && !div_kill) begin
        div_quotient <= q_neg ? -quo : quo;
        div_remainder <= r_neg ? -rem : rem;
      end
    end
  end
endmodule
